// File: rtl/alu_md_if.sv
// Execute-stage bus for alu_md: ALU operands/results and the multiply/divide
// request/status with the architectural HI/LO registers.
interface alu_md_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] S1;
  logic [WIDTH-1:0] S2;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Overflow;
  logic             start;
  logic [2:0]       MDOp;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output S1, S2, ALUControl, start, MDOp,
    input  ALUResult, Zero, Overflow, busy, HI, LO
  );

  modport slave (
    input  S1, S2, ALUControl, start, MDOp,
    output ALUResult, Zero, Overflow, busy, HI, LO
  );
endinterface

// File: rtl/alu_md.sv
// EX-stage unit: combinational ALU plus a multi-cycle multiply / restoring
// divide engine that owns HI/LO.
module alu_md #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic     clk,
  input  logic     reset,
  alu_md_if.slave  bus
);
  localparam int unsigned DIV_LAT = WIDTH;
  localparam int unsigned HW      = WIDTH / 2;
  localparam int unsigned SW      = $clog2(WIDTH);
  localparam int unsigned MAXLAT  = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAXLAT + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  logic [WIDTH-1:0] a, b, sum, dif, res;
  logic [SW-1:0]    shamt;
  logic             ovf;

  assign a     = bus.S1;
  assign b     = bus.S2;
  assign sum   = a + b;
  assign dif   = a - b;
  assign shamt = a[SW-1:0];

  // ALU result and signed overflow
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (bus.ALUControl)
      4'd0:  res = a | b;
      4'd1:  res = {b[HW-1:0], {HW{1'b0}}};
      4'd2:  begin
        res = sum;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3:  begin
        res = dif;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'd4:  res = a & b;
      4'd5:  res = a ^ b;
      4'd6:  res = ~(a | b);
      4'd7:  res = WIDTH'($signed(a) < $signed(b));
      4'd8:  res = WIDTH'(a < b);
      4'd9:  res = b << shamt;
      4'd10: res = b >> shamt;
      4'd11: res = WIDTH'($signed(b) >>> shamt);
      default: res = '0;
    endcase
  end

  assign bus.ALUResult = res;
  assign bus.Zero      = (a == b);
  assign bus.Overflow  = ovf;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             busy_q, sgn, neg_q, neg_r;
  logic [WIDTH-1:0] hi_q, lo_q, op_a, op_b, quo, rem;

  // Full-width product of the captured operands, sign-extended for MULT
  logic [2*WIDTH-1:0] pa, pb, prod;
  assign pa   = sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
  assign pb   = sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
  assign prod = pa * pb;

  // One restoring-division step on magnitudes; op_b holds |divisor|
  logic [WIDTH:0]   rsh, rdiff;
  logic [WIDTH-1:0] quo_nx, rem_nx, q_fix, r_fix;
  assign rsh    = {rem, quo[WIDTH-1]};
  assign rdiff  = rsh - {1'b0, op_b};
  assign quo_nx = {quo[WIDTH-2:0], ~rdiff[WIDTH]};
  assign rem_nx = rdiff[WIDTH] ? rsh[WIDTH-1:0] : rdiff[WIDTH-1:0];
  assign q_fix  = neg_q ? -quo_nx : quo_nx;
  assign r_fix  = neg_r ? -rem_nx : rem_nx;

  logic             a_neg, b_neg, done, accept;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign a_neg  = (bus.MDOp == 3'd2) && a[WIDTH-1];
  assign b_neg  = (bus.MDOp == 3'd2) && b[WIDTH-1];
  assign mag_a  = a_neg ? -a : a;
  assign mag_b  = b_neg ? -b : b;
  assign done   = (state != IDLE) && (cnt == '0);
  assign accept = bus.start && ((state == IDLE) || done);

  // Completion is handled first so a start on the same edge can reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      quo    <= '0;
      rem    <= '0;
      sgn    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        MUL: begin
          if (cnt == '0) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            {hi_q, lo_q} <= prod;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          if (cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (op_b == '0) begin
              lo_q <= '1;
              hi_q <= op_a;
            end else begin
              lo_q <= q_fix;
              hi_q <= r_fix;
            end
          end else begin
            cnt <= cnt - 1'b1;
            quo <= quo_nx;
            rem <= rem_nx;
          end
        end
        default: ;
      endcase

      if (accept) begin
        case (bus.MDOp)
          3'd0, 3'd1: begin
            state  <= MUL;
            busy_q <= 1'b1;
            cnt    <= CW'(MUL_LAT - 1);
            op_a   <= a;
            op_b   <= b;
            sgn    <= ~bus.MDOp[0];
          end
          3'd2, 3'd3: begin
            state  <= DIV;
            busy_q <= 1'b1;
            cnt    <= CW'(DIV_LAT - 1);
            op_a   <= a;
            op_b   <= mag_b;
            quo    <= mag_a;
            rem    <= '0;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
          end
          3'd4:    hi_q <= a;
          3'd5:    lo_q <= a;
          default: ;
        endcase
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: ALU table, mul/div scoreboard, sequencing,
// async reset abort and a WIDTH=16 instance.
module tb_alu_md;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_md_if #(.WIDTH(32)) b32 ();
  alu_md_if #(.WIDTH(16)) b16 ();

  alu_md #(.WIDTH(32), .MUL_LAT(5)) dut   (.clk(clk), .reset(rst_n), .bus(b32));
  alu_md #(.WIDTH(16), .MUL_LAT(5)) dut16 (.clk(clk), .reset(rst_n), .bus(b16));

  typedef struct packed {logic [31:0] hi; logic [31:0] lo;} exp_t;
  typedef struct {logic [3:0] c; logic [31:0] a; logic [31:0] b; logic [31:0] r; logic v;} alu_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    @(negedge clk);
    b32.S1 = a; b32.S2 = b; b32.MDOp = op; b32.start = 1'b1;
    e.hi = ehi; e.lo = elo;
    sb.push_back(e);
    @(negedge clk);
    b32.start = 1'b0;
    b32.S1 = $urandom; b32.S2 = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (b32.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    b32.S1 = '0; b32.S2 = '0; b32.ALUControl = '0; b32.start = 1'b0; b32.MDOp = '0;
    b16.S1 = '0; b16.S2 = '0; b16.ALUControl = '0; b16.start = 1'b0; b16.MDOp = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (b32.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", b32.busy); end
    tests++; if (b32.HI !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", b32.HI); end
    tests++; if (b32.LO !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", b32.LO); end
    tests++; if (b16.busy !== 1'b0 || b16.HI !== 16'h0 || b16.LO !== 16'h0) begin
      fails++; $display("FAIL reset16 got busy=%b hi=%h lo=%h want 0/0/0", b16.busy, b16.HI, b16.LO);
    end
  endtask

  task automatic test_alu();
    alu_t tab[$];
    tab.push_back('{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1});
    tab.push_back('{4'd2,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1});
    tab.push_back('{4'd2,  32'h00000005, 32'hFFFFFFFF, 32'h00000004, 1'b0});
    tab.push_back('{4'd3,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0});
    tab.push_back('{4'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1});
    tab.push_back('{4'd3,  32'h00000001, 32'h80000000, 32'h80000001, 1'b1});
    tab.push_back('{4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0});
    tab.push_back('{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    tab.push_back('{4'd11, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0});
    tab.push_back('{4'd10, 32'h00000004, 32'hF0000000, 32'h0F000000, 1'b0});
    tab.push_back('{4'd9,  32'h00000024, 32'h00000001, 32'h00000010, 1'b0});
    tab.push_back('{4'd1,  32'h00000000, 32'h00001234, 32'h12340000, 1'b0});
    tab.push_back('{4'd1,  32'h00000000, 32'hABCD5678, 32'h56780000, 1'b0});
    tab.push_back('{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 1'b0});
    tab.push_back('{4'd4,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0});
    tab.push_back('{4'd5,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0});
    tab.push_back('{4'd6,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0});
    tab.push_back('{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0});
    tab.push_back('{4'd15, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0});
    foreach (tab[i]) begin
      b32.ALUControl = tab[i].c; b32.S1 = tab[i].a; b32.S2 = tab[i].b;
      #1;
      tests++; if (b32.ALUResult !== tab[i].r) begin
        fails++; $display("FAIL alu[%0d] result got %h want %h", i, b32.ALUResult, tab[i].r);
      end
      tests++; if (b32.Overflow !== tab[i].v) begin
        fails++; $display("FAIL alu[%0d] overflow got %b want %b", i, b32.Overflow, tab[i].v);
      end
      tests++; if (b32.Zero !== (tab[i].a == tab[i].b)) begin
        fails++; $display("FAIL alu[%0d] zero got %b want %b", i, b32.Zero, tab[i].a == tab[i].b);
      end
    end
  endtask

  task automatic test_mul();
    int n;
    exp_t e;
    issue(3'd0, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    wait_idle(n);
    tests++; if (n !== 5) begin fails++; $display("FAIL mult_latency got %0d want 5", n); end
    e = sb.pop_front();
    tests++; if ({b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL mult_result got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
    end
    issue(3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    wait_idle(n);
    tests++; if (n !== 5) begin fails++; $display("FAIL multu_latency got %0d want 5", n); end
    e = sb.pop_front();
    tests++; if ({b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL multu_result got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
    end
  endtask

  task automatic test_div();
    int n;
    exp_t e;
    issue(3'd2, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_idle(n);
    tests++; if (n !== 32) begin fails++; $display("FAIL div_latency got %0d want 32", n); end
    issue(3'd3, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    issue(3'd2, -32'sd9, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF);
    for (int k = 0; k < 4; k++) begin
      logic signed [31:0] x, y;
      x = $signed($urandom);
      y = $signed(32'($urandom_range(1, 100000)));
      if (k == 1) y = -y;
      if (k < 2) issue(3'd2, x, y, 32'(x % y), 32'(x / y));
      else       issue(3'd3, x, y, $unsigned(x) % $unsigned(y), $unsigned(x) / $unsigned(y));
    end
    // issue() already waits per op only for acceptance; results are drained below
  endtask

  task automatic drain_div();
    int n;
    exp_t e;
    e = sb.pop_front();
    tests++; if ({b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL div_result got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
    end
    while (sb.size() > 0) begin
      wait_idle(n);
      e = sb.pop_front();
      tests++; if ({b32.HI, b32.LO} !== e) begin
        fails++; $display("FAIL div_seq_result got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_div_all();
    int n;
    exp_t e;
    exp_t q[$];
    q.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD});
    issue(3'd2, -32'sd7, 32'd2, q[0].hi, q[0].lo);
    wait_idle(n);
    tests++; if (n !== 32) begin fails++; $display("FAIL div_latency got %0d want 32", n); end
    e = sb.pop_front();
    tests++; if ({b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL div_signed got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
    end
    issue(3'd3, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
    wait_idle(n);
    e = sb.pop_front();
    tests++; if ({b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL divu_by_zero got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
    end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    wait_idle(n);
    e = sb.pop_front();
    tests++; if ({b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL div_min_by_m1 got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
    end
    issue(3'd2, -32'sd9, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF);
    wait_idle(n);
    e = sb.pop_front();
    tests++; if ({b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL div_signed_by_zero got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
    end
    for (int k = 0; k < 4; k++) begin
      logic signed [31:0] x, y;
      x = $signed($urandom);
      y = $signed(32'($urandom_range(1, 100000)));
      if (k == 1) y = -y;
      if (k < 2) issue(3'd2, x, y, 32'(x % y), 32'(x / y));
      else       issue(3'd3, x, y, $unsigned(x) % $unsigned(y), $unsigned(x) / $unsigned(y));
      wait_idle(n);
      e = sb.pop_front();
      tests++; if ({b32.HI, b32.LO} !== e) begin
        fails++; $display("FAIL div_rand[%0d] got %h_%h want %h_%h", k, b32.HI, b32.LO, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_moves();
    @(negedge clk);
    b32.S1 = 32'h00001234; b32.MDOp = 3'd4; b32.start = 1'b1;
    @(negedge clk);
    b32.S1 = 32'h00005678; b32.MDOp = 3'd5;
    @(negedge clk);
    b32.start = 1'b0;
    tests++; if (b32.busy !== 1'b0) begin fails++; $display("FAIL move_busy got %b want 0", b32.busy); end
    tests++; if (b32.HI !== 32'h00001234) begin fails++; $display("FAIL mthi got %h want 00001234", b32.HI); end
    tests++; if (b32.LO !== 32'h00005678) begin fails++; $display("FAIL mtlo got %h want 00005678", b32.LO); end
  endtask

  task automatic test_back_to_back();
    int n;
    exp_t e, m;
    issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    @(negedge clk);
    b32.S1 = 32'h0000AAAA; b32.MDOp = 3'd4; b32.start = 1'b1;
    @(negedge clk);
    b32.start = 1'b0;
    tests++; if (b32.HI !== 32'h00001234 || b32.LO !== 32'h00005678 || b32.busy !== 1'b1) begin
      fails++; $display("FAIL mthi_while_busy got hi=%h lo=%h busy=%b want 00001234/00005678/1", b32.HI, b32.LO, b32.busy);
    end
    repeat (29) @(negedge clk);
    b32.S1 = 32'h00010000; b32.S2 = 32'h00010000; b32.MDOp = 3'd1; b32.start = 1'b1;
    m.hi = 32'h1; m.lo = 32'h0;
    sb.push_back(m);
    @(negedge clk);
    b32.start = 1'b0;
    e = sb.pop_front();
    tests++; if ({b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL div_then_mult_div got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
    end
    tests++; if (b32.busy !== 1'b1) begin fails++; $display("FAIL same_edge_accept busy got %b want 1", b32.busy); end
    wait_idle(n);
    tests++; if (n !== 5) begin fails++; $display("FAIL same_edge_mult_latency got %0d want 5", n); end
    e = sb.pop_front();
    tests++; if ({b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL same_edge_mult got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
    end
    issue(3'd1, 32'd3, 32'd4, 32'd0, 32'd12);
    b32.S1 = 32'd1; b32.S2 = 32'd1; b32.MDOp = 3'd3; b32.start = 1'b1;
    repeat (2) @(negedge clk);
    b32.start = 1'b0;
    wait_idle(n);
    tests++; if (n !== 3) begin fails++; $display("FAIL held_start_latency got %0d want 3", n); end
    e = sb.pop_front();
    tests++; if ({b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL held_start_result got %h_%h want %h_%h", b32.HI, b32.LO, e.hi, e.lo);
    end
    @(negedge clk);
    tests++; if (b32.busy !== 1'b0) begin fails++; $display("FAIL dropped_start busy got %b want 0", b32.busy); end
  endtask

  task automatic test_reset_mid();
    int n;
    exp_t e;
    issue(3'd0, 32'h00012345, 32'h10, 32'h0, 32'h00123450);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    tests++; if (b32.busy !== 1'b0 || b32.HI !== 32'h0 || b32.LO !== 32'h0) begin
      fails++; $display("FAIL async_reset got busy=%b hi=%h lo=%h want 0/0/0", b32.busy, b32.HI, b32.LO);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b16.S1 = 16'hFF9C; b16.S2 = 16'd7; b16.MDOp = 3'd2; b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0; b16.S1 = 16'h1111; b16.S2 = 16'h2222;
    n = 0;
    while (b16.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    tests++; if (n !== 16) begin fails++; $display("FAIL div16_latency got %0d want 16", n); end
    tests++; if (b16.LO !== 16'hFFF2 || b16.HI !== 16'hFFFE) begin
      fails++; $display("FAIL div16_result got hi=%h lo=%h want FFFE/FFF2", b16.HI, b16.LO);
    end
    issue(3'd2, 32'd50, -32'sd6, 32'd2, -32'sd8);
    wait_idle(n);
    e = sb.pop_front();
    tests++; if (n !== 32 || {b32.HI, b32.LO} !== e) begin
      fails++; $display("FAIL div_after_reset got n=%0d %h_%h want 32 %h_%h", n, b32.HI, b32.LO, e.hi, e.lo);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_div_all();
    test_moves();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage arithmetic unit for the MIPS datapath: a combinational ALU extended with logic, compare and shift operations plus signed overflow detection, alongside a multi-cycle multiply/divide engine that owns the HI/LO registers. It sits in the EX stage. The ALU path returns its result in the same cycle. The multiply/divide path accepts one operation per start pulse and holds `busy` until HI/LO are written; the pipeline stalls any HI/LO-dependent instruction while `busy`=1.

## Interface
- `WIDTH`, 32, datapath width; must be even and ≥16.
- `MUL_LAT`, 5, busy cycles for MULT/MULTU; must be ≥1.
- `DIV_LAT`, WIDTH, busy cycles for DIV/DIVU; fixed at WIDTH (one quotient bit per cycle).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; clears all state while 0.
- `S1`  in  WIDTH  operand A. Shift amount is `S1[log2(WIDTH)-1:0]`.
- `S2`  in  WIDTH  operand B, and the value that is shifted.
- `ALUControl`  in  4  ALU operation select.
- `ALUResult`  out  WIDTH  combinational ALU result.
- `Zero`  out  1  1 when S1==S2.
- `Overflow`  out  1  signed overflow for ADD/SUB; 0 for all other operations.
- `start`  in  1  single-cycle request for a multiply/divide operation.
- `MDOp`  in  3  multiply/divide operation, sampled together with `start`.
- `busy`  out  1  multiply/divide engine occupied.
- `HI`, `LO`  out  WIDTH  architectural HI/LO registers.

## Operation
- ALUControl encodings:
  - 0 OR; 1 LUI = `S2[WIDTH/2-1:0]` followed by WIDTH/2 zero bits; 2 ADD; 3 SUB.
  - 4 AND; 5 XOR; 6 NOR.
  - 7 SLT (signed) and 8 SLTU (unsigned); each gives 1 or 0, zero-extended.
  - 9 SLL; 10 SRL; 11 SRA.
  - 12–15 give result 0.
- Arithmetic is modulo 2^WIDTH.
- `Overflow`: for ADD, 1 when both operand signs are equal and differ from the result sign. For SUB, 1 when the operand signs differ and the result sign differs from S1's sign.
- MDOp encodings: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI (HI←S1), 5 MTLO (LO←S1), 6–7 no-op.
- Operands are captured into internal registers on the edge that accepts `start`. S1/S2 may change afterwards.
- MULT/MULTU: the 2·WIDTH-bit product is split as {HI,LO}.
- DIV/DIVU: restoring divider. LO = quotient, HI = remainder. For signed divide, the quotient truncates toward zero and the remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = dividend. Applies to both signed and unsigned.
- Signed divide of −2^(WIDTH−1) by −1: LO = −2^(WIDTH−1), HI = 0.
- FSM:
  - IDLE → MUL on `start`&&MDOp∈{0,1}; IDLE → DIV on `start`&&MDOp∈{2,3}.
  - MUL and DIV count down, then return to IDLE.
  - MTHI/MTLO in IDLE write in one cycle and do not leave IDLE.
- `start` while `busy`=1 is ignored, including MTHI/MTLO. HI/LO stay unchanged until the running operation completes.
- `reset` mid-operation aborts it: FSM → IDLE and HI/LO → 0.

## Timing
- Reset values: `busy`=0, HI=0, LO=0, FSM=IDLE, counter=0. ALU outputs are purely combinational.
- A `start` accepted at edge E (MULT/MULTU/DIV/DIVU) sets `busy`=1 from E until edge E+MUL_LAT (or E+DIV_LAT).
- HI/LO update on the edge at which `busy` falls. A new `start` is accepted on that same edge.
- MTHI/MTLO take effect at edge E; `busy` stays 0.
- Back-to-back operations: a `start` held high during `busy`=1 is dropped. The pipeline must re-issue it after `busy` falls.
- `HI`/`LO` are never partially updated while `busy`=1.

## Test plan
- ALU, WIDTH=32:
  - ADD 0x7FFFFFFF+1 → 0x80000000, Overflow=1.
  - SUB 5−5 → 0, Zero=1.
  - SLT −1 vs 1 → 1; SLTU of the same operands → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - LUI S2=0x1234 → 0x12340000.
- MULT S1=−3, S2=7 → `busy` for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU of 0xFFFFFFFF·2 → HI=1, LO=0xFFFFFFFE.
- DIV S1=−7, S2=2 → `busy` for exactly 32 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7.
- DIV 0x80000000 by 0xFFFFFFFF → LO=0x80000000, HI=0.
- Sequencing:
  - MTHI 0xAAAA during a DIV is ignored; the DIV result lands.
  - A MULT started on the same edge as the DIV completion is accepted.
- Reset: assert `reset`=0 mid-MULT, asynchronously with respect to `clk`. `busy`, HI and LO go to 0 immediately. After release, a new DIV completes normally with WIDTH=16 parameterisation (`busy` for 16 cycles).
